// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer: one-hot ALU commands, FSM state
// encoding and the one-hot legality test applied to incoming commands.
package alu_pkg;

  localparam int CMD_W = 6;

  localparam logic [CMD_W-1:0] CMD_SUB = 6'b000001;
  localparam logic [CMD_W-1:0] CMD_ADD = 6'b000010;
  localparam logic [CMD_W-1:0] CMD_SL  = 6'b000100;
  localparam logic [CMD_W-1:0] CMD_XOR = 6'b001000;
  localparam logic [CMD_W-1:0] CMD_OR  = 6'b010000;
  localparam logic [CMD_W-1:0] CMD_AND = 6'b100000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  function automatic logic is_onehot(input logic [CMD_W-1:0] cmd);
    return $countones(cmd) == 1;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter: combinational grant, with the last winner
// remembered so that a tie goes to the other requester.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       resetn,
  input  logic [1:0] valid_i,
  input  logic       accept_i,
  output logic [1:0] grant_o
);

  logic last_q;

  // NOTE: a default assignment at the top of always_comb keeps every path
  // driven, so no latch is inferred.
  always_comb begin
    grant_o = valid_i;
    if (valid_i == 2'b11) grant_o = last_q ? 2'b01 : 2'b10;
  end

  // last_q starts at 1 so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (!resetn)       last_q <= 1'b1;
    else if (accept_i) last_q <= grant_o[1];
  end

endmodule

// File: rtl/alu_sequencer.sv
// Shares one strobed ALU between two requesters: arbitrate, issue the command
// over SETUP/STROBE, capture the result and return a one-cycle response.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CMDW  = 6
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             req0_valid,
  input  logic             req1_valid,
  output logic             req0_ready,
  output logic             req1_ready,
  input  logic [CMDW-1:0]  req0_cmd,
  input  logic [CMDW-1:0]  req1_cmd,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp0_valid,
  output logic             rsp1_valid,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic             ALUenable,
  output logic [CMDW-1:0]  command,
  output logic [WIDTH-1:0] data1,
  output logic [WIDTH-1:0] data2,
  input  logic [WIDTH-1:0] ALUresult,
  input  logic             ALUzero
);

  state_e           state_q;
  logic             owner_q;
  logic             alu_enable_q;
  logic [CMDW-1:0]  command_q;
  logic [WIDTH-1:0] data1_q, data2_q;
  logic             rsp0_valid_q, rsp1_valid_q;
  logic [WIDTH-1:0] rsp_result_q;
  logic             rsp_zero_q, rsp_err_q;

  logic [1:0]       grant;
  logic             accept;
  logic             sel;
  logic [CMDW-1:0]  sel_cmd;
  logic [WIDTH-1:0] sel_a, sel_b;

  rr_arbiter2 u_arb (
    .clk      (clk),
    .resetn   (resetn),
    .valid_i  ({req1_valid, req0_valid}),
    .accept_i (accept),
    .grant_o  (grant)
  );

  assign req0_ready = (state_q == ST_IDLE) && grant[0];
  assign req1_ready = (state_q == ST_IDLE) && grant[1];
  assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);
  assign sel        = grant[1];
  assign sel_cmd    = sel ? req1_cmd : req0_cmd;
  assign sel_a      = sel ? req1_a   : req0_a;
  assign sel_b      = sel ? req1_b   : req0_b;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      owner_q      <= 1'b0;
      alu_enable_q <= 1'b0;
      command_q    <= '0;
      data1_q      <= '0;
      data2_q      <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            owner_q <= sel;
            if (is_onehot(sel_cmd)) begin
              command_q <= sel_cmd;
              data1_q   <= sel_a;
              data2_q   <= sel_b;
              state_q   <= ST_SETUP;
            end else begin
              // Illegal command: answer at once, the ALU is never touched.
              rsp_result_q <= '0;
              rsp_zero_q   <= 1'b0;
              rsp_err_q    <= 1'b1;
              rsp0_valid_q <= ~sel;
              rsp1_valid_q <= sel;
              state_q      <= ST_RESP;
            end
          end
        end
        ST_SETUP: begin
          alu_enable_q <= 1'b1;
          state_q      <= ST_STROBE;
        end
        ST_STROBE: begin
          alu_enable_q <= 1'b0;
          rsp_result_q <= ALUresult;
          rsp_zero_q   <= ALUzero;
          rsp_err_q    <= 1'b0;
          rsp0_valid_q <= ~owner_q;
          rsp1_valid_q <= owner_q;
          state_q      <= ST_RESP;
        end
        ST_RESP:  state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  assign ALUenable  = alu_enable_q;
  assign command    = command_q;
  assign data1      = data1_q;
  assign data2      = data2_q;
  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;
  assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural ALU that evaluates on
// the rising edge of ALUenable.
module tb_alu_sequencer;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [5:0]  req0_cmd, req1_cmd;
  logic [31:0] req0_a, req1_a, req0_b, req1_b;
  logic        rsp0_valid, rsp1_valid;
  logic [31:0] rsp_result;
  logic        rsp_zero, rsp_err;
  logic        ALUenable;
  logic [5:0]  command;
  logic [31:0] data1, data2;
  logic [31:0] ALUresult = '0;
  logic        ALUzero = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  alu_sequencer #(.WIDTH(32), .CMDW(6)) dut (
    .clk(clk), .resetn(resetn),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_cmd(req0_cmd), .req1_cmd(req1_cmd),
    .req0_a(req0_a), .req1_a(req1_a),
    .req0_b(req0_b), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .ALUenable(ALUenable), .command(command),
    .data1(data1), .data2(data2),
    .ALUresult(ALUresult), .ALUzero(ALUzero)
  );

  always #5 clk = ~clk;

  always @(posedge ALUenable) begin
    logic [31:0] r;
    case (command)
      CMD_SUB: r = data1 - data2;
      CMD_ADD: r = data1 + data2;
      CMD_SL:  r = data1 << data2[4:0];
      CMD_XOR: r = data1 ^ data2;
      CMD_OR:  r = data1 | data2;
      CMD_AND: r = data1 & data2;
      default: r = 32'hDEAD_BEEF;
    endcase
    ALUresult = r;
    ALUzero   = (r == 32'd0);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int who, input logic v, input logic [5:0] cmd,
                       input logic [31:0] a, input logic [31:0] b);
    if (who == 0) begin
      req0_valid = v; req0_cmd = cmd; req0_a = a; req0_b = b;
    end else begin
      req1_valid = v; req1_cmd = cmd; req1_a = a; req1_b = b;
    end
  endtask

  // One transaction from a single requester; exp_lat counts negedges from the
  // accept edge to the first negedge where the response strobe is seen.
  task automatic run_op(input string tag, input int who, input logic [5:0] cmd,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input logic exp_zero,
                        input logic exp_err, input int exp_lat);
    int lat, en_cnt, waited;
    logic rdy;
    @(negedge clk);
    drive(who, 1'b1, cmd, a, b);
    #1;
    waited = 0;
    rdy = (who == 0) ? req0_ready : req1_ready;
    while (!rdy && waited < 10) begin
      @(negedge clk); #1;
      waited++;
      rdy = (who == 0) ? req0_ready : req1_ready;
    end
    check({tag, "_ready"}, rdy, 1'b1);
    @(posedge clk);
    @(negedge clk);
    drive(who, 1'b0, 6'b0, 32'd0, 32'd0);
    lat = 1; en_cnt = 0;
    while (!(rsp0_valid || rsp1_valid) && lat < 8) begin
      en_cnt += int'(ALUenable);
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_rsp_own"}, (who == 0) ? rsp0_valid : rsp1_valid, 1'b1);
    check({tag, "_rsp_other"}, (who == 0) ? rsp1_valid : rsp0_valid, 1'b0);
    check({tag, "_result"}, rsp_result, exp_res);
    check({tag, "_zero"}, rsp_zero, exp_zero);
    check({tag, "_err"}, rsp_err, exp_err);
    check({tag, "_en_cycles"}, en_cnt, exp_err ? 0 : 1);
    @(negedge clk);
    check({tag, "_rsp_drop"}, rsp0_valid | rsp1_valid, 1'b0);
    if (!exp_err) check({tag, "_cmd_held"}, command, cmd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0;
    drive(0, 1'b0, 6'b0, 32'd0, 32'd0);
    drive(1, 1'b0, 6'b0, 32'd0, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_en", ALUenable, 1'b0);
    check("rst_cmd", command, 6'b0);
    check("rst_data1", data1, 32'd0);
    check("rst_data2", data2, 32'd0);
    check("rst_rsp", {rsp0_valid, rsp1_valid, rsp_zero, rsp_err}, 4'b0);
    check("rst_result", rsp_result, 32'd0);
    resetn = 1'b1;

    // Tie from reset: req0 first, then req1, then req0 wins the next tie.
    @(negedge clk);
    drive(0, 1'b1, CMD_OR, 32'hF0, 32'h0F);
    drive(1, 1'b1, CMD_SL, 32'h1, 32'd4);
    #1;
    check("tie1_ready0", req0_ready, 1'b1);
    check("tie1_ready1", req1_ready, 1'b0);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b0, 6'b0, 32'd0, 32'd0);
    check("tie1_ready1_setup", req1_ready, 1'b0);
    repeat (2) @(negedge clk);
    check("tie1_rsp0", rsp0_valid, 1'b1);
    check("tie1_rsp1", rsp1_valid, 1'b0);
    check("tie1_result", rsp_result, 32'hFF);
    @(negedge clk); #1;
    check("tie2_ready1", req1_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    drive(1, 1'b0, 6'b0, 32'd0, 32'd0);
    repeat (2) @(negedge clk);
    check("tie2_rsp1", rsp1_valid, 1'b1);
    check("tie2_rsp0", rsp0_valid, 1'b0);
    check("tie2_result", rsp_result, 32'h10);
    @(negedge clk);
    drive(0, 1'b1, CMD_OR, 32'hF0, 32'h0F);
    drive(1, 1'b1, CMD_SL, 32'h1, 32'd4);
    #1;
    check("tie3_ready0", req0_ready, 1'b1);
    check("tie3_ready1", req1_ready, 1'b0);
    drive(0, 1'b0, 6'b0, 32'd0, 32'd0);
    drive(1, 1'b0, 6'b0, 32'd0, 32'd0);

    run_op("add0", 0, CMD_ADD, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0, 3);
    run_op("sub1", 1, CMD_SUB, 32'd9, 32'd9, 32'd0, 1'b1, 1'b0, 3);
    run_op("xor0", 0, CMD_XOR, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 1'b0, 1'b0, 3);
    run_op("err_multi", 0, 6'b000011, 32'd1, 32'd2, 32'd0, 1'b0, 1'b1, 1);
    run_op("err_zero", 0, 6'b000000, 32'd1, 32'd2, 32'd0, 1'b0, 1'b1, 1);

    // Held-valid req0: ready exactly every 4th cycle.
    @(negedge clk);
    drive(0, 1'b1, CMD_ADD, 32'd1, 32'd1);
    for (int i = 0; i < 12; i++) begin
      #1;
      check($sformatf("held_ready_c%0d", i), req0_ready, (i % 4 == 0) ? 1'b1 : 1'b0);
      @(negedge clk);
    end
    drive(0, 1'b0, 6'b0, 32'd0, 32'd0);

    // Reset during STROBE discards the in-flight req1 operation.
    repeat (2) @(negedge clk);
    drive(1, 1'b1, CMD_AND, 32'hFF, 32'h0F);
    #1;
    check("rst_mid_ready", req1_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    drive(1, 1'b0, 6'b0, 32'd0, 32'd0);
    @(negedge clk);
    check("rst_mid_strobe_en", ALUenable, 1'b1);
    resetn = 1'b0;
    @(negedge clk);
    check("rst_mid_en", ALUenable, 1'b0);
    check("rst_mid_rsp1", rsp1_valid, 1'b0);
    check("rst_mid_cmd", command, 6'b0);
    resetn = 1'b1;
    drive(1, 1'b1, CMD_AND, 32'hFF, 32'h0F);
    #1;
    check("rst_mid_idle", req1_ready, 1'b1);
    drive(1, 1'b0, 6'b0, 32'd0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("rst_mid_norsp_%0d", i), rsp1_valid, 1'b0);
    end
    run_op("reissue1", 1, CMD_AND, 32'hFF, 32'h0F, 32'h0F, 1'b0, 1'b0, 3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Controller that shares the single-cycle-strobed ALU between two requesters (req0: execute stage, req1: branch/address unit). It arbitrates round-robin, drives the ALU's one-hot command, operands and `ALUenable` strobe, captures `ALUresult`/`ALUzero` one clock later, and returns a one-cycle response to the winning requester. Sits between the control unit / branch unit and the ALU instance in the datapath.

## Interface
Parameters:
- `WIDTH`, 32: operand/result width (ALU is fixed at 32; other values unsupported).
- `CMDW`, 6: one-hot command width.

Ports (all synchronous to `clk`; one clock; reset is synchronous and active-low):
- `clk`  in  1  system clock, rising edge.
- `resetn`  in  1  synchronous active-low reset.
- `req0_valid`, `req1_valid`  in  1  request pending.
- `req0_ready`, `req1_ready`  out  1  request accepted this cycle (combinational).
- `req0_cmd`, `req1_cmd`  in  CMDW  one-hot command {AND,OR,XOR,SL,ADD,SUB}.
- `req0_a`, `req1_a`  in  WIDTH  operand 1.
- `req0_b`, `req1_b`  in  WIDTH  operand 2.
- `rsp0_valid`, `rsp1_valid`  out  1  one-cycle response strobe per requester.
- `rsp_result`  out  WIDTH  shared result bus.
- `rsp_zero`  out  1  result == 0.
- `rsp_err`  out  1  command was not one-hot; no ALU op performed.
- `ALUenable`  out  1  strobe to ALU (ALU acts on its rising edge).
- `command`  out  CMDW  to ALU.
- `data1`, `data2`  out  WIDTH  to ALU.
- `ALUresult`  in  WIDTH  from ALU.
- `ALUzero`  in  1  from ALU.

## Operation
- FSM states: IDLE, SETUP, STROBE, RESP.
- IDLE: arbiter picks a winner among valid requesters; `reqN_ready` = (state==IDLE) && granted. On `valid && ready`: latch cmd/a/b, record owner.
  - Cmd one-hot → SETUP. Cmd not one-hot (zero or multi-bit) → RESP with `rsp_err`=1, `rsp_result`=0, `rsp_zero`=0; `ALUenable` never pulses.
- SETUP: `command`/`data1`/`data2` driven from latches, `ALUenable`=0 → STROBE.
- STROBE: `ALUenable`=1, command/operands held → RESP; at this transition edge capture `ALUresult`→`rsp_result`, `ALUzero`→`rsp_zero`, `rsp_err`=0.
- RESP: `rsp<owner>_valid`=1 for exactly one cycle; `ALUenable`=0 → IDLE.
- Round-robin: `last` bit flips to owner on each accept. Both valid → grant to requester ≠ `last`; single valid → that requester. After reset `last`=1 (req0 wins first tie).
- Requesters hold valid/cmd/operands stable until ready; dropping valid before accept is legal and commits nothing.
- No back-pressure on responses; requester must sample on `rspN_valid`.
- `command`/`data1`/`data2` retain the last issued values outside SETUP/STROBE.

## Timing
- Registered outputs: `ALUenable`, `command`, `data1`, `data2`, `rsp*`. Only `reqN_ready` is combinational.
- Accept edge E0 → SETUP; E1 → STROBE (`ALUenable` high E1–E2); E2 captures result → RESP (`rspN_valid` high E2–E3); E3 → IDLE.
- Next accept is possible at E4: one op per 4 cycles, latency 3 edges from accept to `rspN_valid` sampled.
- Error path: E0 accept → RESP; `rspN_valid` high E0–E1; IDLE at E1.
- `ALUresult` is sampled one full cycle after the `ALUenable` rising edge.
- Reset values: state IDLE, `ALUenable`=0, `command`=0, `data1`=`data2`=0, `rsp*_valid`=0, `rsp_result`=0, `rsp_zero`=0, `rsp_err`=0, `last`=1.
- Reset asserted mid-operation: next edge forces IDLE, drops `ALUenable`, discards the in-flight response (no `rsp_valid`). Requester must reissue.

## Structure
- Shared package `alu_pkg`:
  - One-hot command constants SUB=000001, ADD=000010, SL=000100, XOR=001000, OR=010000, AND=100000.
  - FSM state encoding.
  - `is_onehot` function.
- One sub-module: `rr_arbiter2` (2-input round-robin, combinational grant plus `last` register updated on accept).

## Test plan
- req0 ADD a=5 b=7 → `ALUenable` high exactly one cycle; `rsp0_valid` 3 edges after accept; `rsp_result`=12, `rsp_zero`=0, `rsp_err`=0.
- req1 SUB a=9 b=9 → `rsp1_valid` only; `rsp_result`=0, `rsp_zero`=1; `rsp0_valid` stays 0.
- Both valid from reset: req0 OR 0xF0|0x0F, req1 SL 1<<4 → req0 served first (result 0xFF), then req1 (result 0x10); next tie goes to req0.
- req0 cmd=000011 → `rsp0_valid` 1 edge after accept, `rsp_err`=1, `rsp_result`=0, `ALUenable` never rises; cmd=000000 gives the same response.
- Reset low during STROBE of req1 AND 0xFF&0x0F → next edge `ALUenable`=0 and state IDLE; no `rsp1_valid`; reissue after reset returns 0x0F.
- req0 held valid continuously with req1 idle → accepts spaced exactly 4 cycles; `req0_ready` low in SETUP/STROBE/RESP.
